multicycle_main_control: RTL
============================

// Module: multicycle_main_control
// PURPOSE
// - Main control FSM for the multicycle MIPS datapath. Sequences the shared ALU, the memory port, the IR, the PC and the register file.
// - Decodes the 6-bit opcode in DECODE.
// - Drives the 2-bit ALUOp consumed by ALU_control: 00 add, 01 sub, 10 use funct.
// - Stalls on a single-signal memory-ready handshake.
// - Counts retired instructions.
// PARAMETERS
// - ADDI_EN  1   1: addi (001000) supported; 0: addi is treated as illegal.
// - CNT_W    32  Width of retired_count.
// PORTS
// - clk           in   1   Rising-edge clock.
// - reset         in   1   Asynchronous, active-high reset.
// - opcode        in   6   IR[31:26]; sampled only in DECODE.
// - mem_ready     in   1   Memory completes the current access this cycle.
// - PCWrite       out  1   Unconditional PC load.
// - PCWriteCond   out  1   PC load if ALU zero.
// - IorD          out  1   0: PC addresses memory; 1: ALUOut addresses memory.
// - MemRead       out  1   Memory read request.
// - MemWrite      out  1   Memory write request.
// - IRWrite       out  1   IR load.
// - MemtoReg      out  1   1: write-back data from MDR.
// - RegDst        out  1   1: rd is destination; 0: rt is destination.
// - RegWrite      out  1   Register-file write.
// - ALUSrcA       out  1   0: PC; 1: A register.
// - ALUSrcB       out  2   00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
// - ALUOp         out  2   To ALU_control.
// - PCSource      out  2   00 ALU result, 01 ALUOut, 10 jump target.
// - state         out  4   Current state, for debug.
// - instr_done    out  1   1-cycle pulse when an instruction retires.
// - illegal_op    out  1   1-cycle pulse in DECODE on an unsupported opcode.
// - retired_count out  CNT_W  Retired-instruction counter.
// BEHAVIOUR
// - State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12. Codes 13-15 go to IDLE.
// - Reset (async): state=IDLE; retired_count=0.
// - In IDLE all outputs are 0. IDLE -> FETCH unconditionally on the next edge.
// - Controls are decoded from state and are 0 unless listed:
//   - FETCH: MemRead, ALUSrcB=01. IRWrite and PCWrite only while mem_ready=1. Holds in FETCH until mem_ready=1, then -> DECODE.
//   - DECODE: ALUSrcB=11. Branches on opcode:
//     - 000000 -> EXECUTE
//     - 100011 / 101011 -> MEM_ADDR
//     - 000100 -> BRANCH
//     - 000010 -> JUMP
//     - 001000 -> ADDI_EX (if ADDI_EN)
//     - else: illegal_op=1, -> FETCH
//   - MEM_ADDR: ALUSrcA=1, ALUSrcB=10. lw -> MEM_READ; sw -> MEM_WRITE. Uses the opcode latched in DECODE.
//   - MEM_READ: MemRead, IorD=1. Waits for mem_ready, then -> MEM_WB.
//   - MEM_WB: RegWrite, MemtoReg=1, RegDst=0, instr_done. -> FETCH.
//   - MEM_WRITE: MemWrite, IorD=1. Waits for mem_ready; instr_done in the ready cycle, then -> FETCH.
//   - EXECUTE: ALUSrcA=1, ALUOp=10. -> R_WB.
//   - R_WB: RegWrite, RegDst=1, instr_done. -> FETCH.
//   - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond, PCSource=01, instr_done. -> FETCH.
//   - JUMP: PCWrite, PCSource=10, instr_done. -> FETCH.
//   - ADDI_EX: ALUSrcA=1, ALUSrcB=10. -> ADDI_WB.
//   - ADDI_WB: RegWrite, RegDst=0, instr_done. -> FETCH.
// - Latency (cycles from FETCH entry, zero-wait memory):
//   - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
//   - Each memory wait cycle adds 1.
// - Handshake: requests are held stable while mem_ready=0. mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
// - retired_count: +1 on every instr_done; wraps 2^CNT_W-1 -> 0. illegal_op does not count.
// - Reset mid-operation: outputs drop to 0 asynchronously, including MemWrite mid-store. The partial instruction is not counted.
// - An opcode change outside DECODE has no effect. mem_ready=1 in the same cycle as reset is ignored.
// STRUCTURE
// - Shared package mips_ctrl_pkg holds:
//   - state localparams
//   - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
//   - ALUOp constants (ALUOP_ADD/SUB/FUNCT)
//   - PCSource and ALUSrcB encodings
// - Single module: state register plus next-state case, output decode case, latched is_store flag, retire counter. No sub-module.
// TESTING
// - Reset, then R-type 000000 with mem_ready=1 -> states 1,2,7,8,1. ALUOp=10 in EXECUTE; RegWrite=1, RegDst=1 in R_WB; retired_count=1.
// - lw 100011 with mem_ready low for 3 cycles in MEM_READ -> MemRead=1, IorD=1 held for 4 cycles. MEM_WB: RegWrite=1, MemtoReg=1. Total 8 cycles.
// - beq 000100 -> BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01. j 000010 -> PCWrite=1, PCSource=10. Each retires in 3 cycles.
// - Opcode 111111 -> illegal_op pulses once in DECODE, then FETCH. retired_count unchanged.
// - Assert reset during MEM_WRITE -> MemWrite=0 before the next clk edge. state=0 then 1. retired_count=0.
// - Preload via CNT_W=4, run 16 R-types -> retired_count wraps to 0. ADDI_EN=0 with opcode 001000 -> illegal_op=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: FSM states, opcodes,
// ALUOp, ALUSrcB and PCSource selector values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EX   = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath; counts retired instructions.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles from FETCH entry with zero-wait memory.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold their requests until mem_ready=1.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int ADDI_EN = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_count
);

    state_t cur_state, nxt_state;
    logic   is_store;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= S_IDLE;
        else       cur_state <= nxt_state;
    end

    // MEM_ADDR picks lw vs sw from this flag, so opcode may change after DECODE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       is_store <= 1'b0;
        else if (cur_state == S_DECODE)  is_store <= (opcode == OP_SW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           retired_count <= '0;
        else if (instr_done) retired_count <= retired_count + CNT_W'(1);
    end

    assign state = cur_state;

    always_comb begin
        nxt_state   = S_IDLE;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;

        case (cur_state)
            S_IDLE: nxt_state = S_FETCH;
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                nxt_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:     nxt_state = S_EXECUTE;
                    OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_J:         nxt_state = S_JUMP;
                    OP_ADDI: begin
                        if (ADDI_EN != 0) begin
                            nxt_state = S_ADDI_EX;
                        end else begin
                            illegal_op = 1'b1;
                            nxt_state  = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_op = 1'b1;
                        nxt_state  = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                nxt_state = is_store ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                nxt_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                nxt_state  = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALUOP_FUNCT;
                nxt_state = S_R_WB;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
                nxt_state   = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                nxt_state = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

endmodule
